if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage with an N-entry prefetch queue between the synchronous IMEM and the OF stage. Fetches ahead while OF is stalled and sustains one instruction per cycle. Flushes the queue and any in-flight IMEM response on an EX branch redirect. Drop-in successor of the current IF stage: same IMEM and OF-side interfaces, plus occupancy and misalignment status.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/sync_fifo_flush.sv | 75 +++++++
 rtl/if_prefetch_stage.sv | 100 ++++++++++
 tb/tb_if_prefetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and widths used by the fetch path.
// Holds the IF->OF payload type and the default prefetch queue depth.
package cpu_pkg;

  localparam int INST_ADDR_WIDTH = 16;
  localparam int INST_DATA_WIDTH = 32;
  localparam int IF_FQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [31:0]                pc;
    logic [INST_DATA_WIDTH-1:0] instr;
  } If_Of_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO of arbitrary element type with a single-cycle flush.
// Flush wins over push and pop; depth need not be a power of two.
module sync_fifo_flush #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              data_i,
  output T              data_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Pointer and count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a prefetch queue between IMEM and OF.
// Credit-based issue keeps every IMEM read landable; redirects flush everything.
module if_prefetch_stage
  import cpu_pkg::*;
#(
  parameter int          FQ_DEPTH        = cpu_pkg::IF_FQ_DEPTH_DEF,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
  parameter int          INST_DATA_WIDTH = cpu_pkg::INST_DATA_WIDTH,
  localparam int         CW              = $clog2(FQ_DEPTH + 1)
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Start,
  output logic                       Imem_En,
  output logic [INST_ADDR_WIDTH-1:0] Imem_Addr,
  input  logic [INST_DATA_WIDTH-1:0] Imem_Data,
  input  logic                       Ex_IsBranchTaken_i,
  input  logic [31:0]                Ex_BranchPC_i,
  output logic                       If_Valid_o,
  output If_Of_t                     If_Payld_o,
  input  logic                       If_Ready_i,
  output logic [CW-1:0]              If_Occupancy_o,
  output logic                       If_MisalignErr_o
);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          misalign_q, misalign_d;
  logic [CW-1:0] fq_count;
  logic [CW:0]   credit_used;
  logic          issue, push, pop;
  If_Of_t        push_data;

  // Queue slots already spoken for, including the read still in flight
  assign credit_used = {1'b0, fq_count} + (CW + 1)'(inflight_q);
  assign issue       = !Rst && Start && !Ex_IsBranchTaken_i &&
                       (credit_used < (CW + 1)'(FQ_DEPTH));
  assign push        = inflight_q && !Ex_IsBranchTaken_i;
  assign pop         = If_Valid_o && If_Ready_i;

  assign push_data.pc    = req_pc_q;
  assign push_data.instr = Imem_Data;

  assign Imem_En          = issue;
  assign Imem_Addr        = fetch_pc_q[INST_ADDR_WIDTH+1:2];
  assign If_Valid_o       = (fq_count != '0) && !Ex_IsBranchTaken_i;
  assign If_Occupancy_o   = fq_count;
  assign If_MisalignErr_o = misalign_q;

  // PC, in-flight and error next-state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    misalign_d = misalign_q;
    if (Ex_IsBranchTaken_i) begin
      fetch_pc_d = align_word(Ex_BranchPC_i);
      misalign_d = misalign_q | (Ex_BranchPC_i[1:0] != 2'b00);
    end else if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = 1'b1;
    end else begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = 1'b0;
    end
  end

  // Fetch-side state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  sync_fifo_flush #(
    .T     (If_Of_t),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Ex_IsBranchTaken_i),
    .data_i  (push_data),
    .data_o  (If_Payld_o),
    .count_o (fq_count)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a payload scoreboard.
// IMEM model returns the word address as the instruction word.
module tb_if_prefetch_stage;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = cpu_pkg::INST_ADDR_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Rst, Start, Imem_En, If_Valid_o, If_Ready_i;
  logic          Ex_IsBranchTaken_i, If_MisalignErr_o;
  logic [AW-1:0] Imem_Addr;
  logic [31:0]   Imem_Data = 32'd0;
  logic [31:0]   Ex_BranchPC_i;
  If_Of_t        If_Payld_o;
  logic [CW-1:0] If_Occupancy_o;

  int tests   = 0;
  int fails   = 0;
  int en_cnt  = 0;
  int pop_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 Clk = ~Clk;

  if_prefetch_stage #(.FQ_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .Start              (Start),
    .Imem_En            (Imem_En),
    .Imem_Addr          (Imem_Addr),
    .Imem_Data          (Imem_Data),
    .Ex_IsBranchTaken_i (Ex_IsBranchTaken_i),
    .Ex_BranchPC_i      (Ex_BranchPC_i),
    .If_Valid_o         (If_Valid_o),
    .If_Payld_o         (If_Payld_o),
    .If_Ready_i         (If_Ready_i),
    .If_Occupancy_o     (If_Occupancy_o),
    .If_MisalignErr_o   (If_MisalignErr_o)
  );

  // Synchronous IMEM: IMEM[k] = k, one-cycle read latency
  always @(posedge Clk) begin
    if (Imem_En === 1'b1) begin
      Imem_Data <= 32'(Imem_Addr);
      en_cnt    <= en_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start_pc, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start_pc + 32'(4 * i));
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: every accepted head must match the next expected fetch
  always @(negedge Clk) begin
    logic [31:0] e;
    if (Rst === 1'b0 && If_Valid_o === 1'b1 && If_Ready_i === 1'b1) begin
      pop_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL pop_unexpected: observed pc %h expected no pop", If_Payld_o.pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("payload", 64'(If_Payld_o), {e, 32'(e[AW+1:2])});
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $error("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int en_base, pop_base;

    Rst = 1'b1; Start = 1'b1; If_Ready_i = 1'b0;
    Ex_IsBranchTaken_i = 1'b0; Ex_BranchPC_i = 32'd0;
    next_cyc(); next_cyc();
    @(negedge Clk);
    check("rst_valid", 64'(If_Valid_o), 64'd0);
    check("rst_occ", 64'(If_Occupancy_o), 64'd0);
    check("rst_misalign", 64'(If_MisalignErr_o), 64'd0);
    check("rst_imem_en", 64'(Imem_En), 64'd0);

    // Streaming from reset
    next_cyc();
    Rst = 1'b0; Start = 1'b1; If_Ready_i = 1'b1;
    push_stream(32'h0, 64);
    @(negedge Clk);
    check("c0_imem_en", 64'(Imem_En), 64'd1);
    check("c0_imem_addr", 64'(Imem_Addr), 64'd0);
    check("c0_valid", 64'(If_Valid_o), 64'd0);
    next_cyc(); @(negedge Clk);
    check("c1_valid", 64'(If_Valid_o), 64'd0);
    next_cyc(); @(negedge Clk);
    check("c2_valid", 64'(If_Valid_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      next_cyc(); @(negedge Clk);
      check("stream_valid", 64'(If_Valid_o), 64'd1);
      check("stream_occ_le1", 64'(If_Occupancy_o <= CW'(1)), 64'd1);
    end

    // Fill from reset with OF stalled
    next_cyc();
    Rst = 1'b1; If_Ready_i = 1'b0;
    @(negedge Clk);
    check("rst2_imem_en", 64'(Imem_En), 64'd0);
    next_cyc();
    Rst = 1'b0;
    push_stream(32'h0, 64);
    en_base = en_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      next_cyc();
    end
    check("fill_pulses", 64'(en_cnt - en_base), 64'd4);
    @(negedge Clk);
    check("fill_occ", 64'(If_Occupancy_o), 64'd4);
    check("fill_imem_en", 64'(Imem_En), 64'd0);
    check("fill_valid", 64'(If_Valid_o), 64'd1);
    next_cyc();
    If_Ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("drain_no_gap", 64'(If_Valid_o), 64'd1);
      next_cyc();
    end

    // Redirect to 0x40 with a read in flight and a loaded queue
    If_Ready_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge Clk);
      got = (Imem_En === 1'b1) && (If_Occupancy_o >= CW'(2));
      next_cyc();
    end
    check("redir_setup", 64'(got), 64'd1);
    push_stream(32'h40, 64);
    Ex_IsBranchTaken_i = 1'b1; Ex_BranchPC_i = 32'h40; If_Ready_i = 1'b1;
    @(negedge Clk);
    check("redir_valid", 64'(If_Valid_o), 64'd0);
    check("redir_imem_en", 64'(Imem_En), 64'd0);
    check("redir_misalign", 64'(If_MisalignErr_o), 64'd0);
    next_cyc();
    Ex_IsBranchTaken_i = 1'b0;
    @(negedge Clk);
    check("redir_next_valid", 64'(If_Valid_o), 64'd0);
    check("redir_target_addr", 64'(Imem_Addr), 64'h10);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      next_cyc(); @(negedge Clk);
      got = (If_Valid_o === 1'b1);
    end
    check("redir_valid_arrives", 64'(got), 64'd1);
    for (int i = 0; i < 4; i++) next_cyc();

    // Misaligned redirect
    push_stream(32'h40, 64);
    Ex_IsBranchTaken_i = 1'b1; Ex_BranchPC_i = 32'h42;
    @(negedge Clk);
    check("mis_imem_en", 64'(Imem_En), 64'd0);
    next_cyc();
    Ex_IsBranchTaken_i = 1'b0;
    @(negedge Clk);
    check("mis_set", 64'(If_MisalignErr_o), 64'd1);
    check("mis_aligned_addr", 64'(Imem_Addr), 64'h10);
    for (int i = 0; i < 6; i++) begin
      next_cyc();
    end
    @(negedge Clk);
    check("mis_sticky", 64'(If_MisalignErr_o), 64'd1);
    check("steady_occ", 64'(If_Occupancy_o), 64'd1);
    check("steady_issue", 64'(Imem_En), 64'd1);

    // Start dropped: queued head plus in-flight read still delivered
    next_cyc();
    Start = 1'b0;
    pop_base = pop_cnt;
    en_base = en_cnt;
    @(negedge Clk);
    check("stop_imem_en", 64'(Imem_En), 64'd0);
    for (int i = 0; i < 5; i++) begin
      next_cyc(); @(negedge Clk);
    end
    check("stop_pops", 64'(pop_cnt - pop_base), 64'd2);
    check("stop_no_fetch", 64'(en_cnt - en_base), 64'd0);
    check("stop_occ", 64'(If_Occupancy_o), 64'd0);
    check("stop_valid", 64'(If_Valid_o), 64'd0);

    // Resume, then reset with three entries queued
    next_cyc();
    Start = 1'b1;
    for (int i = 0; i < 4; i++) next_cyc();
    If_Ready_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge Clk);
      got = (If_Occupancy_o == CW'(3));
      next_cyc();
    end
    check("occ3_reached", 64'(got), 64'd1);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst3_imem_en", 64'(Imem_En), 64'd0);
    next_cyc();
    Rst = 1'b0; Start = 1'b0;
    @(negedge Clk);
    check("rst3_occ", 64'(If_Occupancy_o), 64'd0);
    check("rst3_valid", 64'(If_Valid_o), 64'd0);
    check("rst3_misalign", 64'(If_MisalignErr_o), 64'd0);
    check("rst3_idle", 64'(Imem_En), 64'd0);
    next_cyc();
    Start = 1'b1; If_Ready_i = 1'b1;
    push_stream(32'h0, 64);
    @(negedge Clk);
    check("rst3_first_en", 64'(Imem_En), 64'd1);
    check("rst3_first_addr", 64'(Imem_Addr), 64'd0);
    for (int i = 0; i < 6; i++) next_cyc();
    @(negedge Clk);
    check("rst3_stream_valid", 64'(If_Valid_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
